// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit combinational ALU: fetches operands from a
// local 4x8 register file, issues them, waits ALU_LAT cycles, writes back and responds.
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src_a,
    input  logic [1:0] cmd_src_b,
    input  logic       cmd_imm_en,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 2;
    localparam int unsigned OPW  = 3;
    localparam int unsigned NREG = 4;
    localparam int unsigned CW   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   rf_d [NREG];
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_sel_q, alu_sel_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_result_q, rsp_result_d;
    logic            rsp_carry_q, rsp_carry_d;

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign rd_data    = rf_q[rd_addr];
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;

    // Next-state: issue on accept, count down ALU latency, write back in EXEC
    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    alu_a_d   = rf_q[cmd_src_a];
                    alu_b_d   = cmd_imm_en ? cmd_imm : rf_q[cmd_src_b];
                    alu_sel_d = cmd_op;
                    dst_d     = cmd_dst;
                    if (ALU_LAT == 0) begin
                        state_d = EXEC;
                    end else begin
                        cnt_d   = CW'(ALU_LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            EXEC: begin
                rf_d[dst_q]  = alu_result;
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_valid_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts any in-flight operation with no writeback or response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance with ALU_LAT=0 and one with ALU_LAT=3
// (the latter fed by a 3-cycle delayed ALU), checked against a register-file model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
    logic       cmd_imm_en = 1'b0;
    logic [7:0] cmd_imm = '0;
    logic [1:0] rd_addr = '0;
    logic       sel_u3 = 1'b0;

    logic       cmd_valid0, cmd_ready0, rsp_valid0, rsp_carry0, alu_carry0;
    logic [7:0] alu_a0, alu_b0, alu_result0, rsp_result0, rd_data0;
    logic [2:0] alu_sel0;
    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_carry3, alu_carry3;
    logic [7:0] alu_a3, alu_b3, alu_result3, rsp_result3, rd_data3;
    logic [2:0] alu_sel3;
    logic [8:0] pipe1, pipe2, pipe3;

    logic       s_ready, s_rsp_valid, s_rsp_carry;
    logic [7:0] s_rsp_result, s_rd_data;

    logic [7:0] mrf [2][4];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    // Team ALU behaviour; bit 8 is carry (borrow for SUB, 0 for non-arithmetic ops)
    function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, 8'(a + 8'd1)};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_carry0, alu_result0} = alu_ref(alu_sel0, alu_a0, alu_b0);

    // Slow ALU: its output follows the operands only after three clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe1 <= '0; pipe2 <= '0; pipe3 <= '0;
        end else begin
            pipe1 <= alu_ref(alu_sel3, alu_a3, alu_b3);
            pipe2 <= pipe1;
            pipe3 <= pipe2;
        end
    end
    assign {alu_carry3, alu_result3} = pipe3;

    assign cmd_valid0   = cmd_valid & ~sel_u3;
    assign cmd_valid3   = cmd_valid & sel_u3;
    assign s_ready      = sel_u3 ? cmd_ready3  : cmd_ready0;
    assign s_rsp_valid  = sel_u3 ? rsp_valid3  : rsp_valid0;
    assign s_rsp_result = sel_u3 ? rsp_result3 : rsp_result0;
    assign s_rsp_carry  = sel_u3 ? rsp_carry3  : rsp_carry0;
    assign s_rd_data    = sel_u3 ? rd_data3    : rd_data0;

    alu_cmd_sequencer #(.ALU_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0),
        .alu_result(alu_result0), .alu_carry(alu_carry0),
        .rsp_valid(rsp_valid0), .rsp_result(rsp_result0), .rsp_carry(rsp_carry0),
        .rd_addr(rd_addr), .rd_data(rd_data0)
    );

    alu_cmd_sequencer #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_result(alu_result3), .alu_carry(alu_carry3),
        .rsp_valid(rsp_valid3), .rsp_result(rsp_result3), .rsp_carry(rsp_carry3),
        .rd_addr(rd_addr), .rd_data(rd_data3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int u = 0; u < 2; u++)
            for (int r = 0; r < 4; r++) mrf[u][r] = 8'h00;
    endtask

    // Issue one command to the selected instance and check its response; called at posedge+1
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                           output logic [7:0] res, output logic c);
        logic [7:0] a, b;
        logic [8:0] e;
        int n, lat, u;
        u   = sel_u3 ? 1 : 0;
        lat = sel_u3 ? 3 : 0;
        a   = mrf[u][sa];
        b   = ie ? imm : mrf[u][sb];
        e   = alu_ref(op, a, b);
        cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
        cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
        #1;
        check("ready_idle", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'($urandom);
        cmd_dst    = 2'($urandom);
        cmd_src_a  = 2'($urandom);
        cmd_src_b  = 2'($urandom);
        cmd_imm_en = 1'($urandom);
        cmd_imm    = 8'($urandom);
        n = 1;
        while (!s_rsp_valid && n < 20) begin
            check("busy_ready", 32'(s_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(2 + lat));
        res = s_rsp_result;
        c   = s_rsp_carry;
        check("rsp_result", 32'(res), 32'(e[7:0]));
        check("rsp_carry", 32'(c), 32'(e[8]));
        mrf[u][dst] = e[7:0];
        rd_addr = dst;
        #1;
        check("rd_writeback", 32'(s_rd_data), 32'(mrf[u][dst]));
        check("ready_after", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        check("pulse_len", 32'(s_rsp_valid), 32'd0);
        check("rsp_hold", 32'(s_rsp_result), 32'(e[7:0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       c;
        clear_model();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ready0", 32'(cmd_ready0), 32'd1);
        check("rst_ready3", 32'(cmd_ready3), 32'd1);
        check("rst_rspv0", 32'(rsp_valid0), 32'd0);
        check("rst_rspv3", 32'(rsp_valid3), 32'd0);
        check("rst_sel0", 32'(alu_sel0), 32'd0);
        check("rst_sel3", 32'(alu_sel3), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check("rst_rd0", 32'(rd_data0), 32'd0);
            check("rst_rd3", 32'(rd_data3), 32'd0);
        end
        @(posedge clk); #1;

        // Directed sequence on the zero-latency instance
        sel_u3 = 1'b0;
        run_cmd(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, r, c);
        check("clear_res", 32'(r), 32'h00);
        run_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'hF0, r, c);
        check("add_f0_res", 32'(r), 32'hF0);
        check("add_f0_c", 32'(c), 32'd0);
        run_cmd(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h20, r, c);
        check("add_wrap_res", 32'(r), 32'h10);
        check("add_wrap_c", 32'(c), 32'd1);
        rd_addr = 2'd2; #1;
        check("rd_r2", 32'(rd_data0), 32'h10);
        run_cmd(3'd1, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, r, c);
        check("sub_res", 32'(r), 32'h10);
        check("sub_borrow", 32'(c), 32'd1);
        run_cmd(3'd4, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, r, c);
        check("xor_res", 32'(r), 32'h00);
        check("xor_c", 32'(c), 32'd0);

        // Back-to-back INC r1 with cmd_valid held high
        cmd_op = 3'd6; cmd_dst = 2'd1; cmd_src_a = 2'd1; cmd_src_b = 2'd0;
        cmd_imm_en = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy", 32'(cmd_ready0), 32'd0);
        @(posedge clk); #1;
        check("b2b_rspv1", 32'(rsp_valid0), 32'd1);
        check("b2b_res1", 32'(rsp_result0), 32'hF1);
        check("b2b_ready", 32'(cmd_ready0), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b_gap", 32'(rsp_valid0), 32'd0);
        @(posedge clk); #1;
        check("b2b_rspv2", 32'(rsp_valid0), 32'd1);
        check("b2b_res2", 32'(rsp_result0), 32'hF2);
        mrf[0][1] = 8'hF2;
        @(posedge clk); #1;

        // Latency-3 instance with a slow ALU
        sel_u3 = 1'b1;
        run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, r, c);
        check("lat3_inc", 32'(r), 32'h01);
        run_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h02, r, c);
        check("lat3_add", 32'(r), 32'h03);

        // Randomized commands on both instances
        for (int k = 0; k < 60; k++) begin
            sel_u3 = 1'($urandom);
            run_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), 8'($urandom), r, c);
        end

        // Abort: reset while the zero-latency instance is in EXEC
        sel_u3 = 1'b0;
        cmd_op = 3'd0; cmd_dst = 2'd1; cmd_src_a = 2'd0; cmd_imm_en = 1'b1;
        cmd_imm = 8'h55; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        rd_addr = 2'd1;
        #1;
        check("abort_rspv", 32'(rsp_valid0), 32'd0);
        check("abort_ready", 32'(cmd_ready0), 32'd1);
        check("abort_r1", 32'(rd_data0), 32'd0);
        @(posedge clk); #1;
        check("abort_rspv2", 32'(rsp_valid0), 32'd0);
        run_cmd(3'd6, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, r, c);
        check("post_abort", 32'(r), 32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
